// File: rtl/sub_div32_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
interface sub_div32_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    // Datapath controller side: issues requests, receives results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/sub_div32.sv
// Sequential unsigned restoring divider: one quotient bit per clock, using the
// subtract path (a + ~b + 1) with the carry out taken as "no borrow".
module sub_div32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    sub_div32_if.slave bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] r_work;

    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             div_zero_reg;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step. The partial remainder before the last step is below
    // 2^(WIDTH-1), so dropping r_work's MSB in the shift never loses a bit.
    always_comb begin
        shifted = {r_work[WIDTH-2:0], q_work[WIDTH-1]};
        diff    = {1'b0, shifted} + {1'b0, ~d_reg} + (WIDTH+1)'(1);
        borrow  = ~diff[WIDTH];
        r_next  = borrow ? shifted : diff[WIDTH-1:0];
        q_next  = {q_work[WIDTH-2:0], ~borrow};
    end

    // Control FSM and datapath registers; results change only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            count         <= '0;
            d_reg         <= '0;
            q_work        <= '0;
            r_work        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            div_zero_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            d_reg    <= bus.divisor;
                            q_work   <= bus.dividend;
                            r_work   <= '0;
                            count    <= '0;
                            busy_reg <= 1'b1;
                            state    <= RUN;
                        end else begin
                            quotient_reg  <= '1;
                            remainder_reg <= bus.dividend;
                            div_zero_reg  <= 1'b1;
                            done_reg      <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                RUN: begin
                    r_work <= r_next;
                    q_work <= q_next;
                    count  <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        quotient_reg  <= q_next;
                        remainder_reg <= r_next;
                        div_zero_reg  <= 1'b0;
                        done_reg      <= 1'b1;
                        busy_reg      <= 1'b0;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.quotient  = quotient_reg;
    assign bus.remainder = remainder_reg;
    assign bus.div_zero  = div_zero_reg;
endmodule

// File: tb/tb_sub_div32.sv
// Self-checking bench for sub_div32: scoreboard of expected results pushed at
// request time and popped when done is observed.
module tb_sub_div32;
    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sub_div32_if #(.WIDTH(WIDTH)) bus ();

    sub_div32 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Expected result from a plain arithmetic model.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 1'b0;
        end
        return e;
    endfunction

    // Drive a one-cycle start at the current falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        sb.push_back(model(a, b));
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
    endtask

    // Wait (bounded) for done; edges counts rising edges after the accepting one.
    task automatic wait_done(output int edges, output int busy_cycles);
        edges = 0;
        busy_cycles = 0;
        while (bus.done !== 1'b1 && edges <= 40) begin
            if (bus.busy === 1'b1) busy_cycles++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", bus.done); end
        n_checks++; if (bus.quotient !== '0) begin n_fail++; $display("FAIL reset_quotient got=%h want=0", bus.quotient); end
        n_checks++; if (bus.remainder !== '0) begin n_fail++; $display("FAIL reset_remainder got=%h want=0", bus.remainder); end
        n_checks++; if (bus.div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero got=%b want=0", bus.div_zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Directed operand table, issued back to back at the earliest legal edge.
    task automatic test_directed;
        logic [WIDTH-1:0] av [0:6];
        logic [WIDTH-1:0] bv [0:6];
        exp_t e;
        int edges, bc, want;
        av = '{32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,  32'd0, 32'd5, 32'd12345};
        bv = '{32'd7,   32'd1,         32'hFFFF_FFFF, 32'd10, 32'd5, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            issue(av[i], bv[i]);
            wait_done(edges, bc);
            e = sb.pop_front();
            want = (bv[i] == '0) ? 0 : int'(WIDTH);
            n_checks++; if (edges != want) begin n_fail++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, edges, want); end
            n_checks++; if (bc != want) begin n_fail++; $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, bc, want); end
            n_checks++; if (bus.quotient !== e.q) begin n_fail++; $display("FAIL dir%0d_quotient got=%h want=%h", i, bus.quotient, e.q); end
            n_checks++; if (bus.remainder !== e.r) begin n_fail++; $display("FAIL dir%0d_remainder got=%h want=%h", i, bus.remainder, e.r); end
            n_checks++; if (bus.div_zero !== e.dz) begin n_fail++; $display("FAIL dir%0d_div_zero got=%b want=%b", i, bus.div_zero, e.dz); end
            n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done got=%b want=0", i, bus.busy); end
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse got=%b want=0", i, bus.done); end
            n_checks++; if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_zero !== e.dz) begin
                n_fail++; $display("FAIL dir%0d_held got=%h/%h/%b want=%h/%h/%b", i, bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.dz);
            end
        end
    endtask

    // A start pulse during RUN must be dropped, not queued.
    task automatic test_ignored_start;
        exp_t e;
        int edges, bc, extra;
        issue(32'd100, 32'd7);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(edges, bc);
        e = sb.pop_front();
        n_checks++; if (edges != int'(WIDTH) - 11) begin n_fail++; $display("FAIL ign_latency got=%0d want=%0d", edges, int'(WIDTH) - 11); end
        n_checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            n_fail++; $display("FAIL ign_result got=%0d r %0d want=%0d r %0d", bus.quotient, bus.remainder, e.q, e.r);
        end
        extra = 0;
        @(negedge clk);
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
            @(negedge clk);
        end
        n_checks++; if (extra != 0) begin n_fail++; $display("FAIL ign_not_queued got=%0d active cycles want=0", extra); end
        issue(32'd9, 32'd3);
        wait_done(edges, bc);
        e = sb.pop_front();
        n_checks++; if (bus.done !== 1'b1 || bus.quotient !== e.q || bus.remainder !== e.r) begin
            n_fail++; $display("FAIL ign_next got=%b %0d r %0d want=1 %0d r %0d", bus.done, bus.quotient, bus.remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    // Asynchronous abort mid-RUN, then release reset with start already high.
    task automatic test_abort_reset;
        exp_t e;
        int edges, bc;
        issue(32'd1000, 32'd3);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b want=0", bus.done); end
        n_checks++; if (bus.quotient !== '0 || bus.remainder !== '0 || bus.div_zero !== 1'b0) begin
            n_fail++; $display("FAIL abort_results got=%h/%h/%b want=0/0/0", bus.quotient, bus.remainder, bus.div_zero);
        end
        void'(sb.pop_front());
        @(negedge clk);
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done got=%b want=0", bus.done); end
        bus.start = 1'b1; bus.dividend = 32'd50; bus.divisor = 32'd5;
        sb.push_back(model(32'd50, 32'd5));
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL release_accept got=%b want=1", bus.busy); end
        wait_done(edges, bc);
        e = sb.pop_front();
        n_checks++; if (edges != int'(WIDTH)) begin n_fail++; $display("FAIL release_latency got=%0d want=%0d", edges, WIDTH); end
        n_checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin
            n_fail++; $display("FAIL release_result got=%0d r %0d want=%0d r %0d", bus.quotient, bus.remainder, e.q, e.r);
        end
        @(negedge clk);
    endtask

    // Random operands of varied magnitude, checked against the model and the division invariant.
    task automatic test_random;
        logic [WIDTH-1:0] a, b;
        logic [2*WIDTH-1:0] recon;
        exp_t e;
        int edges, bc;
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = WIDTH'($urandom_range(1, 255));
                2:       b = $urandom >> $urandom_range(0, 31);
                default: b = (i % 25 == 0) ? '0 : WIDTH'($urandom_range(1, 65535));
            endcase
            issue(a, b);
            wait_done(edges, bc);
            e = sb.pop_front();
            n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_timeout a=%h b=%h", i, a, b); end
            n_checks++; if (bus.quotient !== e.q || bus.remainder !== e.r || bus.div_zero !== e.dz) begin
                n_fail++; $display("FAIL rnd%0d_result a=%h b=%h got=%h/%h/%b want=%h/%h/%b", i, a, b, bus.quotient, bus.remainder, bus.div_zero, e.q, e.r, e.dz);
            end
            if (b != '0) begin
                recon = {{WIDTH{1'b0}}, bus.quotient} * {{WIDTH{1'b0}}, b} + {{WIDTH{1'b0}}, bus.remainder};
                n_checks++; if (recon !== {{WIDTH{1'b0}}, a} || bus.remainder >= b) begin
                    n_fail++; $display("FAIL rnd%0d_invariant a=%h b=%h q=%h r=%h", i, a, b, bus.quotient, bus.remainder);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_abort_reset();
        test_random();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover got=%0d want=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
